multi_player_ledger: RTL and testbench

MULTI_PLAYER_LEDGER -- requirements
Module: multi_player_ledger

---
 rtl/multi_player_ledger.sv | 169 ++++++++++++++++
 tb/tb_multi_player_ledger.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_player_ledger.sv
// Multi-account ledger: verified transfers committed as proof-of-work blocks.
// Latency: reject done at T+2, success at nonce k done at T+4+k (start at edge T).
// Backpressure: none; start/init_valid are only honoured while idle (busy low).
// Optional feature macro: LEDGER_KEY_CHECK_EN enables sender key verification.
// Ports: clock/resetn (sync, active-low); init_* write one account while idle;
//   start/sender/receiver/amount/key request a transfer; busy/done/status report
//   progress; prev_hash/last_nonce describe the last block; balance_sel/out read.
module multi_player_ledger #(
  parameter int NUM_PLAYERS = 4,
  parameter int BAL_W       = 8,
  parameter int KEY_W       = 8,
  parameter int HASH_W      = 8,
  parameter int DIFFICULTY  = 2
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           init_valid,
  input  logic [$clog2(NUM_PLAYERS)-1:0] init_player,
  input  logic [BAL_W-1:0]               init_balance,
  input  logic [KEY_W-1:0]               init_key,
  input  logic                           start,
  input  logic [$clog2(NUM_PLAYERS)-1:0] sender,
  input  logic [$clog2(NUM_PLAYERS)-1:0] receiver,
  input  logic [BAL_W-1:0]               amount,
  input  logic [KEY_W-1:0]               key,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     status,
  output logic [HASH_W-1:0]              prev_hash,
  output logic [HASH_W-1:0]              last_nonce,
  input  logic [$clog2(NUM_PLAYERS)-1:0] balance_sel,
  output logic [BAL_W-1:0]               balance_out
);
  localparam int PW = $clog2(NUM_PLAYERS);

  typedef enum logic [2:0] {IDLE, VERIFY, MINE, COMMIT, DONE} state_t;

  state_t            state;
  logic [BAL_W-1:0]  bal [NUM_PLAYERS];
  logic [PW-1:0]     snd;
  logic [PW-1:0]     rcv;
  logic [BAL_W-1:0]  amt;
  logic [HASH_W-1:0] nonce;
  logic [HASH_W-1:0] mined_hash;
  logic [HASH_W-1:0] mined_nonce;

  assign balance_out = bal[balance_sel];

  // Key check: stored keys and the latched key only exist when checking is on.
  logic key_bad;
`ifdef LEDGER_KEY_CHECK_EN
  logic [KEY_W-1:0] keys [NUM_PLAYERS];
  logic [KEY_W-1:0] key_q;
  assign key_bad = (key_q != keys[snd]);
`else
  logic unused_key_bits;
  assign unused_key_bits = ^{key, init_key};
  assign key_bad = 1'b0;
`endif

  // Funds checks; the receiver sum carries one extra bit to catch overflow.
  logic [BAL_W:0] rcv_sum;
  logic           funds_bad;
  assign rcv_sum   = {1'b0, bal[rcv]} + {1'b0, amt};
  assign funds_bad = (amt > bal[snd]) | (snd == rcv) | rcv_sum[BAL_W];

  // Candidate block hash for the current nonce.
  logic [HASH_W-1:0] mix;
  logic [HASH_W-1:0] nonce_x2;
  logic [HASH_W-1:0] cur_hash;
  logic              hash_ok;
  assign mix      = prev_hash ^ amt[HASH_W-1:0] ^ nonce;
  assign nonce_x2 = nonce << 1;
  assign cur_hash = mix + nonce_x2;
  assign hash_ok  = (cur_hash[HASH_W-1 -: DIFFICULTY] == '0);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= 2'b00;
      prev_hash   <= '0;
      last_nonce  <= '0;
      nonce       <= '0;
      mined_hash  <= '0;
      mined_nonce <= '0;
      snd         <= '0;
      rcv         <= '0;
      amt         <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) bal[i] <= '0;
`ifdef LEDGER_KEY_CHECK_EN
      key_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) keys[i] <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // The init write lands on this edge, so VERIFY next cycle sees it.
          if (init_valid) begin
            bal[init_player] <= init_balance;
`ifdef LEDGER_KEY_CHECK_EN
            keys[init_player] <= init_key;
`endif
          end
          if (start) begin
            snd   <= sender;
            rcv   <= receiver;
            amt   <= amount;
`ifdef LEDGER_KEY_CHECK_EN
            key_q <= key;
`endif
            busy  <= 1'b1;
            state <= VERIFY;
          end
        end
        VERIFY: begin
          if (key_bad) begin
            status <= 2'b01;
            done   <= 1'b1;
            state  <= DONE;
          end else if (funds_bad) begin
            status <= 2'b10;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            status <= 2'b00;
            nonce  <= '0;
            state  <= MINE;
          end
        end
        MINE: begin
          if (hash_ok) begin
            mined_hash  <= cur_hash;
            mined_nonce <= nonce;
            state       <= COMMIT;
          end else if (nonce == '1) begin
            // Whole nonce space tried: give up without touching the ledger.
            status <= 2'b11;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            nonce <= nonce + 1'b1;
          end
        end
        COMMIT: begin
          // snd != rcv is guaranteed by VERIFY, so the two writes never collide.
          bal[snd]   <= bal[snd] - amt;
          bal[rcv]   <= bal[rcv] + amt;
          prev_hash  <= mined_hash;
          last_nonce <= mined_nonce;
          done       <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multi_player_ledger.sv
// Directed bench for multi_player_ledger with default parameters.
// Latency: measured in negedge samples after the start edge.
// Backpressure: start during busy is exercised and must be ignored.
module tb_multi_player_ledger;
  logic       clock;
  logic       resetn;
  logic       init_valid;
  logic [1:0] init_player;
  logic [7:0] init_balance;
  logic [7:0] init_key;
  logic       start;
  logic [1:0] sender;
  logic [1:0] receiver;
  logic [7:0] amount;
  logic [7:0] key;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [7:0] prev_hash;
  logic [7:0] last_nonce;
  logic [1:0] balance_sel;
  logic [7:0] balance_out;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int nd;

  multi_player_ledger dut (
    .clock(clock), .resetn(resetn),
    .init_valid(init_valid), .init_player(init_player),
    .init_balance(init_balance), .init_key(init_key),
    .start(start), .sender(sender), .receiver(receiver),
    .amount(amount), .key(key),
    .busy(busy), .done(done), .status(status),
    .prev_hash(prev_hash), .last_nonce(last_nonce),
    .balance_sel(balance_sel), .balance_out(balance_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bal(input string tag, input logic [1:0] p, input logic [7:0] exp);
    balance_sel = p;
    #1;
    chk(tag, {24'd0, balance_out}, {24'd0, exp});
  endtask

  task automatic do_init(input logic [1:0] p, input logic [7:0] b, input logic [7:0] k);
    @(negedge clock);
    init_valid = 1'b1; init_player = p; init_balance = b; init_key = k;
    @(negedge clock);
    init_valid = 1'b0;
  endtask

  // Issues one transfer and watches 40 cycles: first done sample and pulse count.
  task automatic run_txn(input logic [1:0] s, input logic [1:0] r, input logic [7:0] a,
                         input logic [7:0] k, input bit with_init, input logic [1:0] ip,
                         input logic [7:0] ib, input bit poke,
                         output int lat_o, output int nd_o);
    @(negedge clock);
    sender = s; receiver = r; amount = a; key = k; start = 1'b1;
    if (with_init) begin
      init_valid = 1'b1; init_player = ip; init_balance = ib; init_key = k;
    end
    @(negedge clock);
    start = 1'b0; init_valid = 1'b0;
    lat_o = 0; nd_o = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 1) chk("busy_mid_txn", {31'd0, busy}, 32'd1);
      if (done) begin
        nd_o++;
        if (lat_o == 0) lat_o = n;
      end
      if (poke && n <= 2) begin
        start = 1'b1; sender = 2'd0; receiver = 2'd1; amount = 8'd1; key = 8'hA5;
        init_valid = 1'b1; init_player = 2'd0; init_balance = 8'd99; init_key = 8'hA5;
      end else if (poke) begin
        start = 1'b0; init_valid = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    resetn = 1'b0; init_valid = 1'b0; init_player = 2'd0; init_balance = 8'd0;
    init_key = 8'd0; start = 1'b0; sender = 2'd0; receiver = 2'd0;
    amount = 8'd0; key = 8'd0; balance_sel = 2'd0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_status", {30'd0, status}, 32'd0);
    chk("rst_prev_hash", {24'd0, prev_hash}, 32'd0);
    chk("rst_last_nonce", {24'd0, last_nonce}, 32'd0);
    chk_bal("rst_bal0", 2'd0, 8'd0);
    chk_bal("rst_bal3", 2'd3, 8'd0);

    // Basic transfer: nonce 0 hash 0x05 passes
    do_init(2'd0, 8'd20, 8'hA5);
    do_init(2'd1, 8'd3, 8'h3C);
    chk_bal("init_bal0", 2'd0, 8'd20);
    chk_bal("init_bal1", 2'd1, 8'd3);
    run_txn(2'd0, 2'd1, 8'd5, 8'hA5, 1'b0, 2'd0, 8'd0, 1'b0, lat, nd);
    chk("ok_latency", lat, 32'd4);
    chk("ok_done_count", nd, 32'd1);
    chk("ok_status", {30'd0, status}, 32'd0);
    chk_bal("ok_bal0", 2'd0, 8'd15);
    chk_bal("ok_bal1", 2'd1, 8'd8);
    chk("ok_prev_hash", {24'd0, prev_hash}, 32'h05);
    chk("ok_last_nonce", {24'd0, last_nonce}, 32'd0);
    chk("ok_busy_after", {31'd0, busy}, 32'd0);

    // Insufficient funds: 21 from balance 20
    do_init(2'd0, 8'd20, 8'hA5);
    run_txn(2'd0, 2'd1, 8'd21, 8'hA5, 1'b0, 2'd0, 8'd0, 1'b0, lat, nd);
    chk("funds_latency", lat, 32'd2);
    chk("funds_status", {30'd0, status}, 32'd2);
    chk_bal("funds_bal0", 2'd0, 8'd20);
    chk("funds_prev_hash", {24'd0, prev_hash}, 32'h05);

    // Sender equals receiver
    run_txn(2'd0, 2'd0, 8'd1, 8'hA5, 1'b0, 2'd0, 8'd0, 1'b0, lat, nd);
    chk("self_latency", lat, 32'd2);
    chk("self_status", {30'd0, status}, 32'd2);
    chk_bal("self_bal0", 2'd0, 8'd20);

    // Receiver overflow: 250 + 10
    do_init(2'd3, 8'd250, 8'h77);
    run_txn(2'd0, 2'd3, 8'd10, 8'hA5, 1'b0, 2'd0, 8'd0, 1'b0, lat, nd);
    chk("ovf_latency", lat, 32'd2);
    chk("ovf_status", {30'd0, status}, 32'd2);
    chk_bal("ovf_bal3", 2'd3, 8'd250);

    // Long mine: prev 0x05 ^ 0xC0, first passing nonce is 23 (hash 0x00)
    do_init(2'd2, 8'd200, 8'h11);
    do_init(2'd3, 8'd10, 8'h77);
    run_txn(2'd2, 2'd3, 8'hC0, 8'h11, 1'b0, 2'd0, 8'd0, 1'b0, lat, nd);
    chk("mine_latency", lat, 32'd27);
    chk("mine_status", {30'd0, status}, 32'd0);
    chk("mine_last_nonce", {24'd0, last_nonce}, 32'd23);
    chk("mine_prev_hash", {24'd0, prev_hash}, 32'h00);
    chk_bal("mine_bal2", 2'd2, 8'd8);
    chk_bal("mine_bal3", 2'd3, 8'd202);

    // Init of sender balance with start in the same cycle, plus start/init during busy
    run_txn(2'd1, 2'd0, 8'd9, 8'h3C, 1'b1, 2'd1, 8'd50, 1'b1, lat, nd);
    chk("same_cycle_latency", lat, 32'd4);
    chk("busy_start_done_count", nd, 32'd1);
    chk("same_cycle_status", {30'd0, status}, 32'd0);
    chk_bal("same_cycle_bal1", 2'd1, 8'd41);
    chk_bal("same_cycle_bal0", 2'd0, 8'd29);
    chk("same_cycle_prev_hash", {24'd0, prev_hash}, 32'h09);

    // Zero amount mines and commits
    run_txn(2'd0, 2'd1, 8'd0, 8'hA5, 1'b0, 2'd0, 8'd0, 1'b0, lat, nd);
    chk("zero_latency", lat, 32'd4);
    chk("zero_status", {30'd0, status}, 32'd0);
    chk_bal("zero_bal0", 2'd0, 8'd29);
    chk_bal("zero_bal1", 2'd1, 8'd41);

    // Wrong key
    run_txn(2'd0, 2'd1, 8'd5, 8'h00, 1'b0, 2'd0, 8'd0, 1'b0, lat, nd);
`ifdef LEDGER_KEY_CHECK_EN
    chk("key_latency", lat, 32'd2);
    chk("key_status", {30'd0, status}, 32'd1);
    chk_bal("key_bal0", 2'd0, 8'd29);
    chk("key_prev_hash", {24'd0, prev_hash}, 32'h09);
`else
    chk("nokey_latency", lat, 32'd4);
    chk("nokey_status", {30'd0, status}, 32'd0);
    chk_bal("nokey_bal0", 2'd0, 8'd24);
    chk_bal("nokey_bal1", 2'd1, 8'd46);
    chk("nokey_prev_hash", {24'd0, prev_hash}, 32'h0C);
`endif

    // Reset while mining
    @(negedge clock);
    sender = 2'd0; receiver = 2'd1; amount = 8'd1; key = 8'hA5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("abort_busy_verify", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("abort_done_mine", {31'd0, done}, 32'd0);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_status", {30'd0, status}, 32'd0);
    chk("abort_prev_hash", {24'd0, prev_hash}, 32'd0);
    chk("abort_last_nonce", {24'd0, last_nonce}, 32'd0);
    chk_bal("abort_bal0", 2'd0, 8'd0);
    chk_bal("abort_bal1", 2'd1, 8'd0);
    chk_bal("abort_bal2", 2'd2, 8'd0);
    chk_bal("abort_bal3", 2'd3, 8'd0);
    nd = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
